// File: rtl/cp0_ctrl.sv
// CP0 coprocessor control: SR/Cause/EPC/PRId registers, interrupt and
// exception request generation, and mtc0/mfc0/eret handling.
module cp0_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0_addr,
   input  logic [31:0] CP0_in,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] CP0_out,
   output logic [31:0] EPC_out,
   output logic        Req
);

   localparam logic [4:0]  ADDR_SR    = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE = 5'd13;
   localparam logic [4:0]  ADDR_EPC   = 5'd14;
   localparam logic [4:0]  ADDR_PRID  = 5'd15;
   localparam logic [31:0] PRID_VAL   = 32'h2023_0001;

   // SR fields
   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   // Cause fields
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   // EPC
   logic [31:0] epc_q, epc_d;

   logic        int_req, exc_req;

   // Request generation; EXL masks everything so exceptions never nest.
   always_comb begin
      int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
      exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
      Req     = (int_req | exc_req) & ~reset;
   end

   // Next-state: exception entry beats eret, which beats mtc0 for the EXL bit.
   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      ip_d  = HWInt;
      exc_d = exc_q;
      epc_d = epc_q;
      if (Req) begin
         exl_d = 1'b1;
         bd_d  = BDIn;
         exc_d = int_req ? 5'd0 : ExcCodeIn;
         epc_d = {VPC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);
      end else begin
         if (en && CP0_addr == ADDR_SR) begin
            im_d  = CP0_in[15:10];
            exl_d = CP0_in[1];
            ie_d  = CP0_in[0];
         end
         if (en && CP0_addr == ADDR_EPC)
            epc_d = CP0_in;
         if (EXLClr)
            exl_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   // mfc0 read mux; no bypass from the same-cycle write data.
   always_comb begin
      case (CP0_addr)
         ADDR_SR:    CP0_out = {16'b0, im_q, 8'b0, exl_q, ie_q};
         ADDR_CAUSE: CP0_out = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b00};
         ADDR_EPC:   CP0_out = epc_q;
         ADDR_PRID:  CP0_out = PRID_VAL;
         default:    CP0_out = 32'd0;
      endcase
   end

   assign EPC_out = epc_q;

   // Write-data bits with no destination field and the PC byte offset.
   logic unused_bits;
   assign unused_bits = ^{CP0_in[31:16], CP0_in[9:2], VPC[1:0]};

endmodule
